// File: rtl/cv32e40p_prefetch_fifo_ft.sv
// Instruction prefetch FIFO with per-entry parity, outstanding-request flow control
// and discard of stale responses after a branch flush.
module cv32e40p_prefetch_fifo_ft #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PARITY_EN       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branch_req_i,
  input  logic                       trans_issued_i,
  input  logic                       resp_valid_i,
  input  logic [31:0]                resp_rdata_i,
  input  logic                       pop_ready_i,
  output logic                       pop_valid_o,
  output logic [31:0]                pop_rdata_o,
  output logic                       req_allow_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       parity_err_o,
  output logic                       overflow_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING + 1) : 1;
  localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

  typedef enum logic {RUN, FLUSH_WAIT} state_t;

  state_t        state, state_next;
  logic [OW-1:0] discard_cnt, discard_next;

  logic [32:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic [OW-1:0] outstanding, outstanding_next;
  logic          overflow, parity_err;

  logic          full, push_fire, drop_full, pop_fire, head_bad;
  logic [SW-1:0] occupancy;

  assign full      = (cnt == CW'(DEPTH));
  assign push_fire = (state == RUN) && !branch_req_i && resp_valid_i && !full;
  assign drop_full = (state == RUN) && !branch_req_i && resp_valid_i && full;
  assign pop_fire  = !branch_req_i && pop_ready_i && pop_valid_o;
  assign head_bad  = (PARITY_EN != 0) && ((^mem[rd_ptr][31:0]) != mem[rd_ptr][32]);
  assign occupancy = SW'(cnt) + SW'(outstanding);

  always_comb begin
    outstanding_next = outstanding;
    unique case ({trans_issued_i, resp_valid_i})
      2'b10:   if (outstanding != OW'(MAX_OUTSTANDING)) outstanding_next = outstanding + OW'(1);
      2'b01:   if (outstanding != '0) outstanding_next = outstanding - OW'(1);
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      discard_cnt <= '0;
    end else begin
      state       <= state_next;
      discard_cnt <= discard_next;
    end
  end

  // A request issued in the flush cycle already targets the new stream, so
  // only the old in-flight responses are counted for discard.
  always_comb begin
    state_next   = state;
    discard_next = discard_cnt;
    unique case (state)
      RUN: begin
        if (branch_req_i) begin
          discard_next = (resp_valid_i && outstanding != '0) ? outstanding - OW'(1) : outstanding;
          if (discard_next != '0) state_next = FLUSH_WAIT;
        end
      end
      FLUSH_WAIT: begin
        if (resp_valid_i && discard_cnt != '0) discard_next = discard_cnt - OW'(1);
        if (discard_next == '0) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pop_valid_o = (cnt != '0);
    pop_rdata_o = pop_valid_o ? mem[rd_ptr][31:0] : '0;
    req_allow_o = (outstanding < OW'(MAX_OUTSTANDING)) && (occupancy < SW'(DEPTH)) &&
                  (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      outstanding <= '0;
      overflow    <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      outstanding <= outstanding_next;
      parity_err  <= pop_fire && head_bad;
      if (drop_full) overflow <= 1'b1;
      if (branch_req_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push_fire) wr_ptr <= wr_ptr + PW'(1);
        if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
        if (push_fire && !pop_fire)      cnt <= cnt + CW'(1);
        else if (pop_fire && !push_fire) cnt <= cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= {^resp_rdata_i, resp_rdata_i};
  end

  assign cnt_o        = cnt;
  assign overflow_o   = overflow;
  assign parity_err_o = parity_err;

endmodule
